// File: rtl/aes_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared constants and types for the AES-256 key schedule:
//            round/key word counts, round-key type, Rcon table, FSM state
//            encoding and the AES S-box lookup function.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int NR = 14;  // AES-256 rounds, so NR+1 = 15 round keys
  localparam int NK = 8;   // 32-bit words in the cipher key

  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Rcon top bytes indexed by i/2; entry 0 is never selected.
  localparam logic [0:7][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_subword.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : aes_subword
// Purpose  : 32-bit AES SubWord: four independent byte S-box lookups.
// Ports    : word_in  [31:0] - input word
//            word_out [31:0] - S-box substituted word (byte-wise)
// Revision : 1.0 - initial release
// ============================================================================
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_out[8*b +: 8] = sbox(word_in[8*b +: 8]);
  end

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : aes_key_schedule
// Purpose  : Iterative AES-256 key expansion. Produces one 128-bit round key
//            per cycle (rk2..rk14) after rk0/rk1 are loaded from the key, and
//            stores all 15 round keys for random read-out.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous active-high reset
//            start      - expand key (accepted in IDLE or DONE only)
//            key [255:0]- cipher key, w0 in [255:224]
//            busy       - expansion in progress
//            keys_valid - all 15 round keys stored and stable
//            rd_idx[3:0]- round key read index 0..14 (15 reads zero)
//            rd_key[127:0] - round key rd_idx, first word in [127:96]
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NK*32-1:0] key,
  output logic            busy,
  output logic            keys_valid,
  input  logic [3:0]      rd_idx,
  output logic [127:0]    rd_key
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t     state;
  logic [3:0] cnt;
  round_key_t rk_mem [0:NR];

  logic [3:0] idx_m1;
  logic [3:0] idx_m2;
  round_key_t prev1;
  round_key_t prev2;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] rcon_word;
  logic [31:0] temp;
  round_key_t next_rk;

  // rk[i] depends on rk[i-1] (for temp) and rk[i-2] (xor base).
  assign idx_m1 = cnt - 4'd1;
  assign idx_m2 = cnt - 4'd2;
  assign prev1  = rk_mem[idx_m1];
  assign prev2  = rk_mem[idx_m2];

  // Even rounds rotate and add Rcon; odd rounds are a plain SubWord.
  assign sub_in    = cnt[0] ? prev1[31:0] : {prev1[23:0], prev1[31:24]};
  assign rcon_word = cnt[0] ? 32'h0 : {RCON[cnt[3:1]], 24'h0};
  assign temp      = sub_out ^ rcon_word;

  aes_subword u_subword (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  // Single word-chained xor producing all four words of the new round key.
  assign next_rk[127:96] = prev2[127:96] ^ temp;
  assign next_rk[95:64]  = prev2[95:64]  ^ next_rk[127:96];
  assign next_rk[63:32]  = prev2[63:32]  ^ next_rk[95:64];
  assign next_rk[31:0]   = prev2[31:0]   ^ next_rk[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      cnt        <= 4'd0;
      for (int i = 0; i <= NR; i++) begin
        rk_mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rk_mem[0]  <= key[255:128];
            rk_mem[1]  <= key[127:0];
            cnt        <= 4'd2;
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          rk_mem[cnt] <= next_rk;
          if (cnt == LAST_ROUND) begin
            cnt        <= 4'd0;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_key = '0;
    if (rd_idx != 4'd15) begin
      rd_key = rk_mem[rd_idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_aes_key_schedule
// Purpose  : Directed self-checking bench for aes_key_schedule using the
//            FIPS-197 AES-256 key vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_schedule;

  localparam logic [255:0] KEY_A =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_JUNK =
    256'hdeadbeefcafef00d0123456789abcdeffedcba98765432100f1e2d3c4b5a6978;

  localparam logic [127:0] A_RK0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A_RK1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] A_RK2  = 128'ha573c29fa176c498a97fce93a572c09c;
  localparam logic [127:0] A_RK3  = 128'h1651a8cd0244beda1a5da4c10640bade;
  localparam logic [127:0] A_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] B_RK1  = 128'h1f352c073b6108d72d9810a30914dff4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] key = '0;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rd_idx = 4'd0;
  logic [127:0] rd_key;

  int checks = 0;
  int errors = 0;

  aes_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_key(input logic [3:0] idx, output logic [127:0] val);
    rd_idx = idx;
    #1;
    val = rd_key;
  endtask

  task automatic test_reset();
    logic [127:0] v;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, keys_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: busy/keys_valid=%b required 00", {busy, keys_valid});
    end
    for (int i = 0; i < 16; i++) begin
      read_key(4'(i), v);
      checks++;
      if (v !== 128'h0) begin
        errors++;
        $display("FAIL reset_rdkey[%0d]: got %h required 0", i, v);
      end
    end
  endtask

  task automatic test_expand_basic();
    logic [127:0] v;
    start = 1'b1;
    key   = KEY_A;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      checks++;
      if ({busy, keys_valid} !== 2'b10) begin
        errors++;
        $display("FAIL basic_latency cycle %0d: busy/keys_valid=%b required 10", c, {busy, keys_valid});
      end
      tick();
    end
    checks++;
    if ({busy, keys_valid} !== 2'b01) begin
      errors++;
      $display("FAIL basic_done cycle 14: busy/keys_valid=%b required 01", {busy, keys_valid});
    end
    read_key(4'd0, v);
    checks++;
    if (v !== A_RK0) begin errors++; $display("FAIL basic_rk0: got %h required %h", v, A_RK0); end
    read_key(4'd1, v);
    checks++;
    if (v !== A_RK1) begin errors++; $display("FAIL basic_rk1: got %h required %h", v, A_RK1); end
    read_key(4'd2, v);
    checks++;
    if (v !== A_RK2) begin errors++; $display("FAIL basic_rk2: got %h required %h", v, A_RK2); end
    read_key(4'd3, v);
    checks++;
    if (v !== A_RK3) begin errors++; $display("FAIL basic_rk3: got %h required %h", v, A_RK3); end
    read_key(4'd14, v);
    checks++;
    if (v !== A_RK14) begin errors++; $display("FAIL basic_rk14: got %h required %h", v, A_RK14); end
  endtask

  // Also changes key right after acceptance; stored keys must not follow it.
  task automatic test_fips_a3();
    logic [127:0] v;
    start = 1'b1;
    key   = KEY_B;
    tick();
    start = 1'b0;
    key   = KEY_JUNK;
    repeat (13) tick();
    checks++;
    if (keys_valid !== 1'b1) begin
      errors++;
      $display("FAIL fips_valid: keys_valid=%b required 1", keys_valid);
    end
    read_key(4'd1, v);
    checks++;
    if (v !== B_RK1) begin errors++; $display("FAIL fips_rk1: got %h required %h", v, B_RK1); end
    read_key(4'd2, v);
    checks++;
    if (v[127:96] !== 32'h9ba35411) begin
      errors++;
      $display("FAIL fips_rk2_w0: got %h required 9ba35411", v[127:96]);
    end
    read_key(4'd14, v);
    checks++;
    if (v[31:0] !== 32'h706c631e) begin
      errors++;
      $display("FAIL fips_rk14_w3: got %h required 706c631e", v[31:0]);
    end
  endtask

  task automatic test_start_ignored();
    logic [127:0] v;
    start = 1'b1;
    key   = KEY_A;
    tick();                       // cycle 1
    start = 1'b0;
    repeat (4) tick();            // cycle 5
    start = 1'b1;
    key   = KEY_B;
    tick();                       // cycle 6
    start = 1'b0;
    repeat (7) tick();            // cycle 13
    checks++;
    if ({busy, keys_valid} !== 2'b10) begin
      errors++;
      $display("FAIL ignore_cycle13: busy/keys_valid=%b required 10", {busy, keys_valid});
    end
    tick();                       // cycle 14
    checks++;
    if ({busy, keys_valid} !== 2'b01) begin
      errors++;
      $display("FAIL ignore_cycle14: busy/keys_valid=%b required 01", {busy, keys_valid});
    end
    read_key(4'd1, v);
    checks++;
    if (v !== A_RK1) begin errors++; $display("FAIL ignore_rk1: got %h required %h", v, A_RK1); end
    read_key(4'd2, v);
    checks++;
    if (v !== A_RK2) begin errors++; $display("FAIL ignore_rk2: got %h required %h", v, A_RK2); end
    read_key(4'd14, v);
    checks++;
    if (v !== A_RK14) begin errors++; $display("FAIL ignore_rk14: got %h required %h", v, A_RK14); end
  endtask

  task automatic test_rst_mid_expand();
    logic [127:0] v;
    start = 1'b1;
    key   = KEY_A;
    tick();                       // cycle 1
    start = 1'b0;
    repeat (6) tick();            // cycle 7
    rst = 1'b1;
    tick();                       // cycle 8
    rst = 1'b0;
    checks++;
    if ({busy, keys_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_flags: busy/keys_valid=%b required 00", {busy, keys_valid});
    end
    for (int i = 0; i < 16; i++) begin
      read_key(4'(i), v);
      checks++;
      if (v !== 128'h0) begin
        errors++;
        $display("FAIL rstmid_rdkey[%0d]: got %h required 0", i, v);
      end
    end
    repeat (3) tick();
    checks++;
    if ({busy, keys_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_idle: busy/keys_valid=%b required 00", {busy, keys_valid});
    end
    start = 1'b1;
    key   = KEY_A;
    tick();
    start = 1'b0;
    repeat (13) tick();
    checks++;
    if ({busy, keys_valid} !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_restart_done: busy/keys_valid=%b required 01", {busy, keys_valid});
    end
    read_key(4'd14, v);
    checks++;
    if (v !== A_RK14) begin errors++; $display("FAIL rstmid_rk14: got %h required %h", v, A_RK14); end
  endtask

  // Entered from DONE holding KEY_A keys.
  task automatic test_done_restart();
    logic [127:0] v;
    start = 1'b1;
    key   = KEY_B;
    checks++;
    if (keys_valid !== 1'b1) begin
      errors++;
      $display("FAIL restart_cycle0: keys_valid=%b required 1", keys_valid);
    end
    tick();
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      checks++;
      if (keys_valid !== 1'b0) begin
        errors++;
        $display("FAIL restart_invalid cycle %0d: keys_valid=%b required 0", c, keys_valid);
      end
      tick();
    end
    checks++;
    if (keys_valid !== 1'b1) begin
      errors++;
      $display("FAIL restart_valid: keys_valid=%b required 1", keys_valid);
    end
    read_key(4'd2, v);
    checks++;
    if (v[127:96] !== 32'h9ba35411) begin
      errors++;
      $display("FAIL restart_rk2_w0: got %h required 9ba35411", v[127:96]);
    end
    read_key(4'd15, v);
    checks++;
    if (v !== 128'h0) begin errors++; $display("FAIL restart_idx15: got %h required 0", v); end
  endtask

  // Entered from DONE; rst wins over start in the same cycle.
  task automatic test_rst_with_start();
    logic [127:0] v;
    rst   = 1'b1;
    start = 1'b1;
    key   = KEY_A;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({busy, keys_valid} !== 2'b00) begin
        errors++;
        $display("FAIL rststart_flags step %0d: busy/keys_valid=%b required 00", c, {busy, keys_valid});
      end
      tick();
    end
    read_key(4'd1, v);
    checks++;
    if (v !== 128'h0) begin errors++; $display("FAIL rststart_rk1: got %h required 0", v); end
  endtask

  initial begin
    test_reset();
    test_expand_basic();
    test_fips_a3();
    test_start_ignored();
    test_rst_mid_expand();
    test_done_restart();
    test_rst_with_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
